// File: rtl/gomoku_turn_ctrl.sv
// gomoku_turn_ctrl: game sequencing for an N x N gomoku board.
// Owns the game FSM, board RAM sweep/write-back, key capture, the per-turn
// countdown, win scores and draw detection. Judging is done externally.
module gomoku_turn_ctrl #(
    parameter int EDGE_BITS     = 3,
    parameter int TIMEOUT_TICKS = 15,
    parameter int SCORE_BITS    = 4,
    localparam int AW           = 2 * EDGE_BITS,
    localparam int CW           = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  power,
    input  logic                  restart,
    input  logic                  tick,
    input  logic                  key_valid,
    input  logic                  key_x_sel,
    input  logic [EDGE_BITS-1:0]  key_coord,
    output logic                  key_ready,
    input  logic                  confirm,
    output logic                  judge_en,
    output logic                  judge_color,
    output logic [AW-1:0]         judge_pos,
    input  logic                  judge_done,
    input  logic [1:0]            judge_result,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [1:0]            ram_data,
    output logic [2:0]            state,
    output logic                  active_side,
    output logic                  pos_ready,
    output logic [CW-1:0]         countdown,
    output logic [SCORE_BITS-1:0] red_score,
    output logic [SCORE_BITS-1:0] green_score,
    output logic                  game_over,
    output logic                  draw
);

    localparam logic [2:0] ST_STOPPED = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_JUDGE   = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;
    localparam logic [2:0] ST_END     = 3'd5;

    localparam logic [AW-1:0]         LAST_CELL    = {AW{1'b1}};
    localparam logic [CW-1:0]         TIMEOUT_LOAD = CW'(TIMEOUT_TICKS);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX    = {SCORE_BITS{1'b1}};

    logic [2:0]            state_reg, state_next;
    logic [AW-1:0]         clr_cnt_reg, clr_cnt_next;
    logic [EDGE_BITS-1:0]  x_reg, x_next;
    logic [EDGE_BITS-1:0]  y_reg, y_next;
    logic                  x_got_reg, x_got_next;
    logic                  y_got_reg, y_got_next;
    logic                  side_reg, side_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [AW-1:0]         piece_reg, piece_next;
    logic [SCORE_BITS-1:0] red_reg, red_next;
    logic [SCORE_BITS-1:0] green_reg, green_next;
    logic                  over_reg, over_next;
    logic                  draw_reg, draw_next;
    logic                  win_reg, win_next;
    logic [2:0]            conf_sync_reg;
    logic                  confirm_down;

    // Two-flop synchroniser for the raw OK button plus a delay stage for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conf_sync_reg <= 3'b000;
        else        conf_sync_reg <= {conf_sync_reg[1:0], confirm};
    end

    assign confirm_down = conf_sync_reg[1] & ~conf_sync_reg[2];

    // Next-state and datapath update; power/restart override all normal transitions
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        x_got_next   = x_got_reg;
        y_got_next   = y_got_reg;
        side_next    = side_reg;
        cnt_next     = cnt_reg;
        piece_next   = piece_reg;
        red_next     = red_reg;
        green_next   = green_reg;
        over_next    = over_reg;
        draw_next    = draw_reg;
        win_next     = win_reg;
        if (!power) begin
            state_next = ST_STOPPED;
            red_next   = '0;
            green_next = '0;
        end else if (restart) begin
            state_next   = ST_CLEAR;
            clr_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_STOPPED: begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
                ST_CLEAR: begin
                    clr_cnt_next = clr_cnt_reg + AW'(1);
                    if (clr_cnt_reg == LAST_CELL) begin
                        state_next = ST_WAIT;
                        side_next  = 1'b0;
                        piece_next = '0;
                        x_got_next = 1'b0;
                        y_got_next = 1'b0;
                        x_next     = '0;
                        y_next     = '0;
                        over_next  = 1'b0;
                        draw_next  = 1'b0;
                        cnt_next   = TIMEOUT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (key_valid) begin
                        if (key_x_sel) begin
                            x_next     = key_coord;
                            x_got_next = 1'b1;
                        end else begin
                            y_next     = key_coord;
                            y_got_next = 1'b1;
                        end
                    end
                    // A confirm beats a simultaneous timeout
                    if (confirm_down && x_got_reg && y_got_reg) begin
                        state_next = ST_JUDGE;
                    end else if (tick) begin
                        if (cnt_reg <= CW'(1)) begin
                            side_next  = ~side_reg;
                            x_got_next = 1'b0;
                            y_got_next = 1'b0;
                            cnt_next   = TIMEOUT_LOAD;
                        end else begin
                            cnt_next = cnt_reg - CW'(1);
                        end
                    end
                end
                ST_JUDGE: begin
                    if (judge_done) begin
                        if (judge_result == 2'd1 || judge_result == 2'd2) begin
                            state_next = ST_COMMIT;
                            win_next   = (judge_result == 2'd2);
                        end else begin
                            // Invalid (and the undefined code 3): same side retries
                            state_next = ST_WAIT;
                            x_got_next = 1'b0;
                            y_got_next = 1'b0;
                            cnt_next   = TIMEOUT_LOAD;
                        end
                    end
                end
                ST_COMMIT: begin
                    x_got_next = 1'b0;
                    y_got_next = 1'b0;
                    if (win_reg) begin
                        state_next = ST_END;
                        over_next  = 1'b1;
                        if (side_reg) begin
                            if (green_reg != SCORE_MAX) green_next = green_reg + SCORE_BITS'(1);
                        end else begin
                            if (red_reg != SCORE_MAX) red_next = red_reg + SCORE_BITS'(1);
                        end
                    end else if (piece_reg == LAST_CELL) begin
                        state_next = ST_END;
                        over_next  = 1'b1;
                        draw_next  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        piece_next = piece_reg + AW'(1);
                        side_next  = ~side_reg;
                        cnt_next   = TIMEOUT_LOAD;
                    end
                end
                ST_END: begin
                    state_next = ST_END;
                end
                default: begin
                    state_next = ST_STOPPED;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_STOPPED;
            clr_cnt_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            x_got_reg   <= 1'b0;
            y_got_reg   <= 1'b0;
            side_reg    <= 1'b0;
            cnt_reg     <= '0;
            piece_reg   <= '0;
            red_reg     <= '0;
            green_reg   <= '0;
            over_reg    <= 1'b0;
            draw_reg    <= 1'b0;
            win_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            x_got_reg   <= x_got_next;
            y_got_reg   <= y_got_next;
            side_reg    <= side_next;
            cnt_reg     <= cnt_next;
            piece_reg   <= piece_next;
            red_reg     <= red_next;
            green_reg   <= green_next;
            over_reg    <= over_next;
            draw_reg    <= draw_next;
            win_reg     <= win_next;
        end
    end

    // Decoded outputs: the RAM port follows the current state so a COMMIT write
    // still lands even if restart arrives in that cycle
    always_comb begin
        ram_we   = (state_reg == ST_CLEAR) || (state_reg == ST_COMMIT);
        ram_addr = (state_reg == ST_CLEAR) ? clr_cnt_reg : {y_reg, x_reg};
        ram_data = (state_reg == ST_COMMIT) ? (side_reg ? 2'b10 : 2'b01) : 2'b00;
    end

    assign key_ready   = key_valid;
    assign judge_en    = (state_reg == ST_JUDGE);
    assign judge_color = side_reg;
    assign judge_pos   = {y_reg, x_reg};
    assign state       = state_reg;
    assign active_side = side_reg;
    assign pos_ready   = x_got_reg & y_got_reg;
    assign countdown   = cnt_reg;
    assign red_score   = red_reg;
    assign green_score = green_reg;
    assign game_over   = over_reg;
    assign draw        = draw_reg;

endmodule

// File: doc/gomoku_turn_ctrl.md
# gomoku_turn_ctrl

Parametrised turn/game controller for the N×N gomoku board. It generalises the fixed 8×8 top-level sequencing with a configurable board edge, a per-turn countdown that forfeits the turn on timeout, per-side win scores, and explicit draw detection. The block owns the game FSM, board-RAM clearing and write-back, and key capture. It talks to an external judger, RAM, LED scanner and buzzer through the ports below.

## Interface
Parameters:
- EDGE_BITS, 3, board edge = 2^EDGE_BITS; N = 2^(2*EDGE_BITS) cells.
- TIMEOUT_TICKS, 15, `tick` pulses allowed per turn (≥1).
- SCORE_BITS, 4, width of each win counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- power  in  1  level; 0 forces STOPPED.
- restart  in  1  level; 1 forces CLEAR.
- tick  in  1  one-cycle time-base pulse, e.g. 1 Hz.
- key_valid  in  1  keyboard coordinate available.
- key_x_sel  in  1  1 = coordinate is x, 0 = y.
- key_coord  in  EDGE_BITS  coordinate value.
- key_ready  out  1  equals key_valid; keys are always consumed.
- confirm  in  1  raw OK button, level.
- judge_en  out  1  high throughout JUDGE.
- judge_color  out  1  side to move; 0 = red, 1 = green.
- judge_pos  out  2*EDGE_BITS  {y,x}.
- judge_done  in  1  judger result valid, sampled only in JUDGE.
- judge_result  in  2  0 invalid, 1 valid, 2 win.
- ram_we / ram_addr / ram_data  out  1 / 2*EDGE_BITS / 2  board write port.
- state  out  3  current FSM state.
- active_side  out  1  side to move.
- pos_ready  out  1  both x and y captured; drives point-flicker enable.
- countdown  out  $clog2(TIMEOUT_TICKS+1)  ticks remaining.
- red_score, green_score  out  SCORE_BITS  wins per side.
- game_over, draw  out  1  END flags.

## Operation
- States: STOPPED=0, CLEAR=1, WAIT=2, JUDGE=3, COMMIT=4, END=5. Encoding 6–7 → STOPPED next cycle.
- Override priority, evaluated every cycle: ~power → STOPPED, which also zeroes scores. Otherwise restart → CLEAR, which keeps scores. Otherwise the normal transitions below apply.
- STOPPED → CLEAR when power=1.
- CLEAR:
  - A sweep counter starts at 0 on entry, including re-entry from CLEAR.
  - Each cycle: ram_we=1, ram_addr=counter, ram_data=00.
  - After addr N-1 → WAIT.
  - On entry to WAIT from CLEAR: active_side=red, piece_count=0, keys cleared, game_over=draw=0.
- WAIT:
  - key_valid with key_x_sel=1 latches x and sets x_got; key_x_sel=0 latches y and sets y_got. A later key overwrites the earlier value.
  - Keys are captured only in WAIT.
  - pos_ready = x_got & y_got.
  - confirm_down (rising edge after a 2-flop sync) with pos_ready → JUDGE.
  - Every WAIT entry loads countdown=TIMEOUT_TICKS. Each tick decrements it.
  - A tick arriving while countdown=1 is a timeout: toggle active_side, clear keys, reload countdown, stay in WAIT.
  - confirm_down together with timeout: confirm wins, no toggle.
- JUDGE:
  - On judge_done: invalid → WAIT, same side, keys cleared.
  - valid or win → COMMIT.
- COMMIT (exactly 1 cycle):
  - Write: ram_we=1, ram_addr={y,x}, ram_data = red ? 01 : 10. Keys cleared.
  - win → END, game_over=1, winner's score +1 (saturating at all-ones).
  - valid with piece_count=N-1 → END, game_over=1, draw=1.
  - Otherwise piece_count+1, side toggled → WAIT.
- END: holds until restart or ~power.
- Outside CLEAR/COMMIT, ram_we=0.

## Timing
- All outputs are registered except key_ready, judge_en, ram_we/addr/data and pos_ready, which decode the registered state.
- Reset values: state=STOPPED; all counters, scores, flags, coordinates = 0; active_side=red.
- Confirm path: the edge of confirm rising before clk edge k is registered at k; the FSM enters JUDGE at k+2.
- CLEAR lasts exactly N cycles.
- JUDGE→COMMIT→WAIT/END: 1 cycle after the judge_done cycle, then 1 cycle in COMMIT.
- judge_pos/judge_color are stable for the whole JUDGE state.
- restart asserted mid-COMMIT: the RAM write still happens that cycle, because ram_we decodes the current state; the next state is CLEAR.

## Test plan
- Power-up, EDGE_BITS=3: power=1 → exactly 64 cycles of CLEAR writing 00 to addresses 0..63 → WAIT with active_side=0, countdown=15.
- Keys x=3, y=5, confirm; judger returns valid → one COMMIT write addr 0x2B, data 01 → WAIT with active_side=1.
- Judger returns invalid → no RAM write, active_side unchanged, pos_ready=0, countdown=15.
- Timeout: 15 ticks in WAIT with no confirm → active_side toggles, countdown=15. Confirm on the same cycle as the 15th tick → JUDGE, no toggle.
- Win by green → END, green_score=1. restart → CLEAR with score kept. power=0 → scores 0. 16 wins by red saturate red_score at 15.
- EDGE_BITS=1 (4 cells): 4 valid moves → END with draw=1, game_over=1. restart asserted inside CLEAR restarts the sweep at address 0.
